// File: rtl/stage_sequencer.sv
// Multi-cycle LEGv8 control sequencer. It walks each instruction through FETCH/DECODE/EXECUTE/(MEMORY)/WRITEBACK,
// issues one-cycle stage strobes, resolves the branch select and counts retired instructions and memory stalls.
module stage_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch,
  input  logic             uncond_branch,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             wb_en,
  output logic             mem_req,
  output logic             pc_write,
  output logic             pc_src,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_ERROR     = 3'd7
  } state_e;

  localparam int                WAIT_W    = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_e            state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              branch_q, branch_d;
  logic              uncond_branch_q, uncond_branch_d;
  logic              pc_src_q, pc_src_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              halt_pending_q, halt_pending_d;
  logic              one_shot_q, one_shot_d;
  logic              err_q, err_d;
  logic              fetch_en_q, fetch_en_d;
  logic              decode_en_q, decode_en_d;
  logic              exec_en_q, exec_en_d;
  logic              mem_req_q, mem_req_d;
  logic              wb_en_q, wb_en_d;
  logic              pc_write_q, pc_write_d;
  logic              busy_q, busy_d;

  always_comb begin
    // NOTE: every _d gets a default first so this block can never infer a latch.
    state_d         = state_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    branch_d        = branch_q;
    uncond_branch_d = uncond_branch_q;
    pc_src_d        = pc_src_q;
    wait_cnt_d      = wait_cnt_q;
    instr_count_d   = instr_count_q;
    stall_count_d   = stall_count_q;
    halt_pending_d  = halt_pending_q;
    one_shot_d      = one_shot_q;
    err_d           = err_q;

    if (halt_req && (state_q != ST_IDLE) && (state_q != ST_ERROR)) halt_pending_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end else if (step) begin
          state_d    = ST_FETCH;
          one_shot_d = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        mem_read_d      = mem_read;
        mem_write_d     = mem_write;
        branch_d        = branch;
        uncond_branch_d = uncond_branch;
        state_d         = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        pc_src_d = uncond_branch_q | (branch_q & zero);
        if (mem_read_q || mem_write_q) begin
          state_d    = ST_MEMORY;
          wait_cnt_d = '0;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        // A ready arriving on the last allowed cycle still completes the access.
        if (mem_ready) begin
          state_d = ST_WRITEBACK;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          if (stall_count_q != CNT_MAX) stall_count_d = stall_count_q + CNT_W'(1);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_WRITEBACK: begin
        instr_count_d  = instr_count_q + CNT_W'(1);
        halt_pending_d = 1'b0;
        one_shot_d     = 1'b0;
        if (halt_pending_q || halt_req || !run || one_shot_q) state_d = ST_IDLE;
        else                                                  state_d = ST_FETCH;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so no input reaches a strobe combinationally.
    fetch_en_d  = (state_d == ST_FETCH);
    decode_en_d = (state_d == ST_DECODE);
    exec_en_d   = (state_d == ST_EXECUTE);
    mem_req_d   = (state_d == ST_MEMORY);
    pc_write_d  = (state_d == ST_WRITEBACK);
    wb_en_d     = (state_d == ST_WRITEBACK) && !(mem_write_q || branch_q || uncond_branch_q);
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      branch_q        <= 1'b0;
      uncond_branch_q <= 1'b0;
      pc_src_q        <= 1'b0;
      wait_cnt_q      <= '0;
      instr_count_q   <= '0;
      stall_count_q   <= '0;
      halt_pending_q  <= 1'b0;
      one_shot_q      <= 1'b0;
      err_q           <= 1'b0;
      fetch_en_q      <= 1'b0;
      decode_en_q     <= 1'b0;
      exec_en_q       <= 1'b0;
      mem_req_q       <= 1'b0;
      wb_en_q         <= 1'b0;
      pc_write_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every flop updates together from the _d values.
      state_q         <= state_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      branch_q        <= branch_d;
      uncond_branch_q <= uncond_branch_d;
      pc_src_q        <= pc_src_d;
      wait_cnt_q      <= wait_cnt_d;
      instr_count_q   <= instr_count_d;
      stall_count_q   <= stall_count_d;
      halt_pending_q  <= halt_pending_d;
      one_shot_q      <= one_shot_d;
      err_q           <= err_d;
      fetch_en_q      <= fetch_en_d;
      decode_en_q     <= decode_en_d;
      exec_en_q       <= exec_en_d;
      mem_req_q       <= mem_req_d;
      wb_en_q         <= wb_en_d;
      pc_write_q      <= pc_write_d;
      busy_q          <= busy_d;
    end
  end

  assign fetch_en    = fetch_en_q;
  assign decode_en   = decode_en_q;
  assign exec_en     = exec_en_q;
  assign wb_en       = wb_en_q;
  assign mem_req     = mem_req_q;
  assign pc_write    = pc_write_q;
  assign pc_src      = pc_src_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign state       = state_q;
  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: random instruction streams checked cycle by cycle against a
// per-instruction stage list and running counter model derived from the sequencing rules.
module tb_stage_sequencer;

  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 15;

  localparam int S_IDLE = 0, S_F = 1, S_D = 2, S_E = 3, S_M = 4, S_WB = 5, S_ERR = 7;

  // {mem_read, mem_write, branch, uncond_branch}
  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_LDUR = 4'b1000;
  localparam logic [3:0] C_STUR = 4'b0100;
  localparam logic [3:0] C_CBZ  = 4'b0010;
  localparam logic [3:0] C_B    = 4'b0001;

  logic clk = 1'b0;
  logic reset, run, step, halt_req;
  logic mem_read, mem_write, branch, uncond_branch, zero, mem_ready;
  logic fetch_en, decode_en, exec_en, wb_en, mem_req, pc_write, pc_src, busy, err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count, stall_count;

  always #5 clk = ~clk;

  stage_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .uncond_branch(uncond_branch),
    .zero(zero), .mem_ready(mem_ready),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .mem_req(mem_req), .pc_write(pc_write), .pc_src(pc_src), .busy(busy), .err(err),
    .state(state), .instr_count(instr_count), .stall_count(stall_count)
  );

  logic [12:0] obs;
  assign obs = {state, fetch_en, decode_en, exec_en, mem_req, wb_en, pc_write, pc_src, busy, err};

  int n_checks = 0;
  int n_pass   = 0;

  logic [CNT_W-1:0] m_icnt   = '0;
  logic [CNT_W-1:0] m_stall  = '0;
  bit               m_pc_src = 1'b0;

  // Expected output word for a cycle spent in stage st.
  function automatic logic [12:0] exp_vec(input int st, input bit wb_ok, input bit src);
    return {3'(st), st == S_F, st == S_D, st == S_E, st == S_M, (st == S_WB) && wb_ok,
            st == S_WB, src, !(st == S_IDLE || st == S_ERR), st == S_ERR};
  endfunction

  task automatic random_inputs();
    {mem_read, mem_write, branch, uncond_branch} = 4'($urandom);
    zero      = 1'($urandom);
    mem_ready = 1'($urandom);
  endtask

  task automatic start_from_idle(input bit run_v, input bit step_v);
    run      = run_v;
    step     = step_v;
    halt_req = 1'($urandom);
    random_inputs();
    @(negedge clk);
    step     = 1'b0;
    halt_req = 1'b0;
  endtask

  // Runs one instruction starting at a negedge inside its FETCH cycle; ends one negedge after WRITEBACK.
  task automatic do_instr(input logic [3:0] ctl, input bit z, input int waits, input bit halt_dec,
                          input bit halt_wb, input bit run_wb, input bit shot, input bit never_ready,
                          input string tag);
    int          stages[$];
    int          stall_now, mk, st, end_st;
    bit          wb_ok, src, rdy;
    logic [12:0] ev;
    wb_ok     = !(ctl[2] | ctl[1] | ctl[0]);
    src       = ctl[0] | (ctl[1] & z);
    stall_now = 0;
    mk        = 0;
    stages.push_back(S_F);
    stages.push_back(S_D);
    stages.push_back(S_E);
    if (never_ready) for (int k = 0; k < MEM_TIMEOUT; k++) stages.push_back(S_M);
    else if (ctl[3] | ctl[2]) for (int k = 0; k <= waits; k++) stages.push_back(S_M);
    if (!never_ready) stages.push_back(S_WB);

    for (int i = 0; i < stages.size(); i++) begin
      st = stages[i];
      ev = exp_vec(st, wb_ok, (st == S_M || st == S_WB) ? src : m_pc_src);
      n_checks++;
      if (obs !== ev) $display("FAIL %s outputs cyc%0d: got %b expected %b", tag, i, obs, ev);
      else n_pass++;
      n_checks++;
      if ({instr_count, stall_count} !== {m_icnt, m_stall + CNT_W'(stall_now)})
        $display("FAIL %s counters cyc%0d: got icnt=%0d stall=%0d expected icnt=%0d stall=%0d",
                 tag, i, instr_count, stall_count, m_icnt, m_stall + CNT_W'(stall_now));
      else n_pass++;

      random_inputs();
      halt_req = 1'b0;
      rdy      = 1'b0;
      case (st)
        S_D: begin
          {mem_read, mem_write, branch, uncond_branch} = ctl;
          halt_req = halt_dec;
        end
        S_E: begin
          {mem_read, mem_write, branch, uncond_branch} = ctl;
          zero = z;
        end
        S_M: begin
          rdy       = !never_ready && (mk == waits);
          mem_ready = rdy;
        end
        S_WB: begin
          run      = run_wb;
          halt_req = halt_wb;
        end
        default: ;
      endcase
      @(negedge clk);
      if (st == S_M) begin
        if (!rdy) stall_now++;
        mk++;
      end
    end

    halt_req = 1'b0;
    m_stall  = m_stall + CNT_W'(stall_now);
    m_pc_src = src;
    if (never_ready) begin
      end_st = S_ERR;
    end else begin
      m_icnt = m_icnt + CNT_W'(1);
      end_st = (halt_dec || halt_wb || !run_wb || shot) ? S_IDLE : S_F;
    end
    ev = exp_vec(end_st, wb_ok, m_pc_src);
    n_checks++;
    if (obs !== ev) $display("FAIL %s next-state outputs: got %b expected %b", tag, obs, ev);
    else n_pass++;
    n_checks++;
    if ({instr_count, stall_count} !== {m_icnt, m_stall})
      $display("FAIL %s retire counters: got icnt=%0d stall=%0d expected icnt=%0d stall=%0d",
               tag, instr_count, stall_count, m_icnt, m_stall);
    else n_pass++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      run      = 1'b0;
      step     = 1'b0;
      halt_req = 1'($urandom);
      random_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec(S_IDLE, 1'b0, m_pc_src))
        $display("FAIL idle outputs cyc%0d: got %b expected %b", i, obs, exp_vec(S_IDLE, 1'b0, m_pc_src));
      else n_pass++;
      n_checks++;
      if ({instr_count, stall_count} !== {m_icnt, m_stall})
        $display("FAIL idle counters cyc%0d: got icnt=%0d stall=%0d expected icnt=%0d stall=%0d",
                 i, instr_count, stall_count, m_icnt, m_stall);
      else n_pass++;
    end
    halt_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run      = 1'b1;
      step     = 1'($urandom);
      halt_req = 1'($urandom);
      random_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== 13'd0 || instr_count !== '0 || stall_count !== '0)
        $display("FAIL reset state cyc%0d: got outputs=%b icnt=%0d stall=%0d expected all zero",
                 i, obs, instr_count, stall_count);
      else n_pass++;
    end
    run      = 1'b1;
    step     = 1'b0;
    halt_req = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_run();
    for (int i = 0; i < 3; i++) do_instr(C_ADD, 1'($urandom), 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "add_run");
  endtask

  task automatic test_ldur();
    do_instr(C_LDUR, 1'($urandom), 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ldur_wait3");
    do_instr(C_LDUR, 1'($urandom), 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ldur_wait0");
    do_instr(C_LDUR, 1'($urandom), MEM_TIMEOUT - 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ldur_ready_wins");
  endtask

  task automatic test_stur_cbz();
    do_instr(C_STUR, 1'($urandom), 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "stur");
    do_instr(C_CBZ, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "cbz_taken");
    do_instr(C_CBZ, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cbz_not_taken");
    idle_cycles(2);
  endtask

  task automatic test_step();
    start_from_idle(1'b0, 1'b1);
    do_instr(C_ADD, 1'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "step_one");
    idle_cycles(3);
    start_from_idle(1'b0, 1'b1);
    do_instr(C_B, 1'($urandom), 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "step_two_run_late");
    start_from_idle(1'b1, 1'b1);
    do_instr(C_LDUR, 1'($urandom), 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "run_and_step_a");
    do_instr(C_ADD, 1'($urandom), 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "run_and_step_b");
    do_instr(C_CBZ, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "run_and_step_c");
    idle_cycles(2);
  endtask

  task automatic test_halt();
    start_from_idle(1'b1, 1'b0);
    do_instr(C_ADD, 1'($urandom), 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "halt_in_decode");
    start_from_idle(1'b1, 1'b0);
    do_instr(C_LDUR, 1'($urandom), 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "halt_in_wb");
    start_from_idle(1'b1, 1'b0);
    do_instr(C_ADD, 1'($urandom), 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "after_halt_a");
    do_instr(C_STUR, 1'($urandom), 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_halt_b");
    idle_cycles(1);
  endtask

  task automatic test_random_stream();
    logic [3:0] ctl;
    int         kind, h;
    bit         last, hd, hw;
    start_from_idle(1'b1, 1'b0);
    for (int n = 0; n < 30; n++) begin
      kind = int'($urandom_range(0, 4));
      ctl  = (kind == 0) ? C_ADD : (kind == 1) ? C_LDUR : (kind == 2) ? C_STUR : (kind == 3) ? C_CBZ : C_B;
      h    = int'($urandom_range(0, 7));
      hd   = (h == 0);
      hw   = (h == 1);
      last = (n == 29);
      do_instr(ctl, 1'($urandom), int'($urandom_range(0, 6)), hd, hw, !last, 1'b0, 1'b0, "random");
      if (!last && (hd || hw)) start_from_idle(1'b1, 1'b0);
    end
    idle_cycles(1);
  endtask

  task automatic test_timeout();
    start_from_idle(1'b1, 1'b0);
    do_instr(C_LDUR, 1'($urandom), 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "timeout");
    for (int i = 0; i < 4; i++) begin
      run      = 1'b1;
      step     = 1'($urandom);
      halt_req = 1'($urandom);
      random_inputs();
      @(negedge clk);
      n_checks++;
      if (obs !== exp_vec(S_ERR, 1'b0, m_pc_src) || {instr_count, stall_count} !== {m_icnt, m_stall})
        $display("FAIL error hold cyc%0d: got outputs=%b icnt=%0d stall=%0d expected outputs=%b icnt=%0d stall=%0d",
                 i, obs, instr_count, stall_count, exp_vec(S_ERR, 1'b0, m_pc_src), m_icnt, m_stall);
      else n_pass++;
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 13'd0 || instr_count !== '0 || stall_count !== '0)
      $display("FAIL reset from error: got outputs=%b icnt=%0d stall=%0d expected all zero",
               obs, instr_count, stall_count);
    else n_pass++;
    m_icnt   = '0;
    m_stall  = '0;
    m_pc_src = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    halt_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    start_from_idle(1'b1, 1'b0);
    do_instr(C_ADD, 1'($urandom), 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "pre_reset_add");
    {mem_read, mem_write, branch, uncond_branch} = C_LDUR;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_vec(S_M, 1'b1, 1'b0))
      $display("FAIL midreset memory entry: got %b expected %b", obs, exp_vec(S_M, 1'b1, 1'b0));
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({instr_count, stall_count} !== {m_icnt, m_stall + CNT_W'(1)})
      $display("FAIL midreset stall: got icnt=%0d stall=%0d expected icnt=%0d stall=%0d",
               instr_count, stall_count, m_icnt, m_stall + CNT_W'(1));
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== 13'd0 || instr_count !== '0 || stall_count !== '0)
      $display("FAIL midreset drop: got outputs=%b icnt=%0d stall=%0d expected all zero",
               obs, instr_count, stall_count);
    else n_pass++;
    m_icnt   = '0;
    m_stall  = '0;
    m_pc_src = 1'b0;
    run      = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle_cycles(2);
  endtask

  initial begin
    reset    = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    halt_req = 1'b0;
    {mem_read, mem_write, branch, uncond_branch, zero, mem_ready} = 6'd0;
    test_reset();
    test_add_run();
    test_ldur();
    test_stur_cbz();
    test_step();
    test_halt();
    test_random_stream();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time 200000, expected finish well before");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control sequencer for the LEGv8 single-cycle datapath. It replaces the free-running oscillator plus fixed delay taps with one clock and a state machine. Every instruction walks FETCH → DECODE → EXECUTE → (MEMORY) → WRITEBACK, and each stage gets a one-cycle enable strobe. Data-memory accesses use a req/ready handshake with a wait-state timeout. Branch resolution (pc_src) is computed here, along with run/step/halt control and instruction and stall counters.

## Interface
- CNT_W, 32: width of instr_count and stall_count
- MEM_TIMEOUT, 15: maximum MEMORY wait cycles before the ERROR state; legal range 1..255
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; while high, instructions execute back-to-back
- step  in  1  pulse; in IDLE with run low, executes exactly one instruction
- halt_req  in  1  pulse; latched, honored at the end of the current instruction
- mem_read, mem_write, branch, uncond_branch  in  1 each  decoded control, valid from the DECODE cycle onward
- zero  in  1  ALU zero flag, valid in the EXECUTE cycle
- mem_ready  in  1  data memory completion
- fetch_en, decode_en, exec_en, wb_en  out  1 each  single-cycle stage strobes
- mem_req  out  1  data memory request
- pc_write  out  1  PC update strobe
- pc_src  out  1  branch-taken select for the PC mux
- busy  out  1  high in every state except IDLE and ERROR
- err  out  1  sticky memory-timeout flag
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, ERROR=7
- instr_count  out  CNT_W  retired instructions
- stall_count  out  CNT_W  total MEMORY wait cycles

## Operation
- **IDLE**
  - If run=1 → FETCH.
  - Else if step=1 → FETCH, and one_shot is set.
  - run takes priority over step.
- **FETCH:** fetch_en=1 → DECODE.
- **DECODE:** decode_en=1; mem_read, mem_write, branch and uncond_branch are latched → EXECUTE.
- **EXECUTE:** exec_en=1.
  - pc_src_r is latched as uncond_branch | (branch & zero).
  - If latched mem_read|mem_write → MEMORY, else → WRITEBACK.
- **MEMORY:** mem_req=1, held continuously.
  - mem_ready=1 → WRITEBACK.
  - Each cycle spent in MEMORY with mem_ready=0 increments wait_cnt and stall_count.
  - If wait_cnt reaches MEM_TIMEOUT with mem_ready=0 → ERROR. If mem_ready=1 in that same cycle, ready wins.
- **WRITEBACK**
  - pc_write=1.
  - wb_en = ~(mem_write | branch | uncond_branch), using the latched values.
  - instr_count increments; it wraps from 2^CNT_W−1 to 0.
  - Next state is IDLE if halt_pending, or run=0, or one_shot; otherwise FETCH.
  - halt_pending and one_shot clear on leaving WRITEBACK.
- **ERROR:** err=1 and all strobes 0. Exit only by reset.
- **halt_req:** sets halt_pending in any state other than IDLE or ERROR, including a halt_req in the WRITEBACK cycle itself, which is honored at that WRITEBACK. halt_req in IDLE is ignored.
- **pc_src output:** equals pc_src_r and holds until the next EXECUTE. It is 0 after reset.
- **wait_cnt:** clears on entering MEMORY.
- **stall_count:** saturates at its maximum value (no wrap).

## Timing
- **Reset (reset=0):**
  - state=IDLE.
  - All strobes, mem_req, pc_src, busy and err = 0.
  - Counters, latches, halt_pending and one_shot = 0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to a strobe.
- Strobes are high for exactly one clk cycle. mem_req is high for every MEMORY cycle.
- **Instruction latency:**
  - Non-memory instructions: 4 cycles (F, D, E, WB).
  - Memory instructions: 5 + wait cycles, where wait = cycles with mem_ready low.
- Back-to-back throughput: FETCH of instruction n+1 is the cycle immediately after WRITEBACK of instruction n.
- **Reset asserted mid-instruction:** immediate return to IDLE. The PC is not written, no count increments, and a partially serviced mem_req drops the same cycle.
- mem_ready sampled outside MEMORY is ignored.

## Test plan
- Reset release with run=1 (ADD: no memory, no branch) → state sequence 1,2,3,5,1; wb_en=1 and pc_write=1 in cycle 4; instr_count=1 after cycle 4, 3 after 12 cycles.
- LDUR with mem_ready delayed 3 cycles → MEMORY lasts 4 cycles with mem_req high throughout; stall_count=3; wb_en=1; latency 8 cycles.
- STUR, then CBZ with zero=1, then CBZ with zero=0 → STUR gives wb_en=0; the first CBZ gives pc_src=1 from the cycle after EXECUTE and wb_en=0; the second CBZ gives pc_src=0.
- run=0, step pulse in IDLE → exactly one instruction, then IDLE; instr_count=1. A second step gives 2. run=1 with step both asserted → continuous execution.
- halt_req pulsed during DECODE with run=1 → instruction completes, IDLE after WRITEBACK, busy=0. halt_req during WRITEBACK also stops after that instruction.
- mem_ready held 0 with MEM_TIMEOUT=15 → ERROR after 15 wait cycles; err=1, state=7, stall_count=15. Reset asserted → all outputs 0, state=0.
